// File: rtl/servo_pos_sequencer_pkg.sv
// servo_pkg: shared position type, sequencer FSM states and position limits.
package servo_pkg;
  typedef logic [7:0] pos_t;
  typedef enum logic [1:0] {IDLE, SLEW, DWELL} seq_state_e;
  localparam pos_t POS_MIN = 8'd0;
  localparam pos_t POS_MAX = 8'd255;
endpackage

// File: rtl/servo_pos_sequencer_if.sv
// servo_pos_sequencer_if: command handshake plus position/status outputs of the sequencer.
interface servo_pos_sequencer_if #(
  parameter int DEPTH = 4
) ();
  import servo_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic busy;
  pos_t cmd_pos;
  pos_t pos;
  logic [$clog2(DEPTH):0] level;
  modport master (output cmd_valid, cmd_pos, input cmd_ready, pos, busy, level);
  modport slave (input cmd_valid, cmd_pos, output cmd_ready, pos, busy, level);
endinterface

// File: rtl/servo_cmd_fifo.sv
// servo_cmd_fifo: DEPTH-entry target FIFO; simultaneous push and pop keep level unchanged.
module servo_cmd_fifo
  import servo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  pos_t                   din,
  output pos_t                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  pos_t mem_q [DEPTH];
  pos_t mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    level_d = level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  assign dout = mem_q[rd_q];
  assign full = level_q == LW'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
endmodule

// File: rtl/servo_pos_sequencer.sv
// servo_pos_sequencer: queues target positions and slews pos toward each by STEP per tick.
// Define SERVO_SEQ_DWELL_EN to hold each reached target for DWELL_TICKS ticks.
module servo_pos_sequencer
  import servo_pkg::*;
#(
  parameter int   TICK_DIV    = 4096,
  parameter int   STEP        = 4,
  parameter int   DEPTH       = 4,
  parameter pos_t RESET_POS   = 8'd128,
  parameter int   DWELL_TICKS = 8
) (
  input logic                  clk,
  input logic                  rstn,
  servo_pos_sequencer_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int LW = $clog2(DEPTH) + 1;
  if (TICK_DIV < 2 || STEP < 1 || STEP > 255 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DWELL_TICKS < 0) begin : g_bad_param
    $error("servo_pos_sequencer: illegal parameter set");
  end
  logic [CW-1:0] cnt_q, cnt_d;
  seq_state_e state_q, state_d;
  pos_t pos_q, pos_d, tgt_q, tgt_d, head, next_pos;
  logic tick, push, pop, full, empty, hit;
  logic [8:0] diff;
  logic [LW-1:0] level;
`ifdef SERVO_SEQ_DWELL_EN
  localparam int DW = $clog2(DWELL_TICKS + 2);
  logic [DW-1:0] dwell_q, dwell_d;
`endif
  servo_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rstn(rstn), .push(push), .pop(pop), .din(bus.cmd_pos),
    .dout(head), .full(full), .empty(empty), .level(level)
  );
  assign tick = cnt_q == CW'(TICK_DIV - 1);
  assign push = bus.cmd_valid & ~full;
  assign diff = (tgt_q >= pos_q) ? {1'b0, tgt_q} - {1'b0, pos_q} : {1'b0, pos_q} - {1'b0, tgt_q};
  assign hit = diff <= 9'(STEP);
  // The final step lands exactly on the target, so pos can never wrap.
  assign next_pos = hit ? tgt_q : (tgt_q > pos_q ? pos_q + 8'(STEP) : pos_q - 8'(STEP));
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    state_d = state_q;
    pos_d = pos_q;
    tgt_d = tgt_q;
    pop = 1'b0;
`ifdef SERVO_SEQ_DWELL_EN
    dwell_d = dwell_q;
`endif
    unique case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        tgt_d = head;
        state_d = SLEW;
      end
      SLEW: if (tick) begin
        pos_d = next_pos;
`ifdef SERVO_SEQ_DWELL_EN
        dwell_d = '0;
        state_d = hit ? DWELL : SLEW;
`else
        state_d = hit ? IDLE : SLEW;
`endif
      end
`ifdef SERVO_SEQ_DWELL_EN
      DWELL: if (tick) begin
        dwell_d = dwell_q + DW'(1);
        state_d = (dwell_d == DW'(DWELL_TICKS)) ? IDLE : DWELL;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt_q <= '0;
      state_q <= IDLE;
      pos_q <= RESET_POS;
      tgt_q <= RESET_POS;
    end else begin
      cnt_q <= cnt_d;
      state_q <= state_d;
      pos_q <= pos_d;
      tgt_q <= tgt_d;
    end
`ifdef SERVO_SEQ_DWELL_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) dwell_q <= '0;
    else dwell_q <= dwell_d;
`endif
  assign bus.pos = pos_q;
  assign bus.cmd_ready = ~full;
  assign bus.busy = (state_q != IDLE) | ~empty;
  assign bus.level = level;
endmodule

// File: tb/tb_servo_pos_sequencer.sv
// tb_servo_pos_sequencer: directed and random commands checked cycle by cycle against a queue-based model.
module tb_servo_pos_sequencer;
  localparam int TICK_DIV = 4;
  localparam int STEP = 8;
  localparam int DEPTH = 4;
  localparam int DWELL_TICKS = 2;
`ifdef SERVO_SEQ_DWELL_EN
  localparam bit DW_EN = 1'b1;
`else
  localparam bit DW_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  servo_pos_sequencer_if #(.DEPTH(DEPTH)) bus ();
  servo_pos_sequencer #(
    .TICK_DIV(TICK_DIV), .STEP(STEP), .DEPTH(DEPTH), .RESET_POS(8'd128), .DWELL_TICKS(DWELL_TICKS)
  ) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end
  int m_pos, m_tgt, m_state, m_hold, m_cnt;
  int q[$];
  int m_log[$];
  bit saw_full;
  task automatic mreset();
    m_pos = 128; m_tgt = 128; m_state = 0; m_hold = 0; m_cnt = 0;
    q.delete();
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // One clock: advance the model at the edge, then compare all outputs at the falling edge.
  task automatic cyc();
    bit tk, psh;
    int d;
    @(posedge clk);
    if (!rstn) mreset();
    else begin
      tk = (m_cnt == TICK_DIV - 1);
      psh = bus.cmd_valid && q.size() < DEPTH;
      if (m_state == 0) begin
        if (q.size() > 0) begin
          m_tgt = q.pop_front();
          m_log.push_back(m_tgt);
          m_state = 1;
        end
      end else if (tk && m_state == 1) begin
        d = m_tgt - m_pos;
        if (d <= STEP && d >= -STEP) begin
          m_pos = m_tgt;
          m_state = DW_EN ? 2 : 0;
          m_hold = DWELL_TICKS;
        end else m_pos = m_pos + (d > 0 ? STEP : -STEP);
      end else if (tk && m_state == 2) begin
        m_hold--;
        if (m_hold == 0) m_state = 0;
      end
      if (psh) q.push_back(int'(bus.cmd_pos));
      m_cnt = (m_cnt + 1) % TICK_DIV;
    end
    @(negedge clk);
    if (bus.level == 3'd4 && bus.cmd_ready == 1'b0) saw_full = 1'b1;
    check("pos", bus.pos, m_pos);
    check("level", bus.level, q.size());
    check("cmd_ready", bus.cmd_ready, q.size() < DEPTH);
    check("busy", bus.busy, m_state != 0 || q.size() > 0);
  endtask
  task automatic push(input int v);
    bit acc;
    acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_pos = 8'(v);
    for (int i = 0; i < 400 && !acc; i++) begin
      acc = bus.cmd_ready;
      cyc();
    end
    bus.cmd_valid = 1'b0;
    check("push_accepted", acc, 1);
  endtask
  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim && bus.busy; i++) cyc();
    check("idle_reached", bus.busy, 0);
  endtask
  initial begin
    int vals[$];
    int times[$];
    int prev, t_a, t_b;
    int exp_log[7];
    bus.cmd_valid = 1'b0;
    bus.cmd_pos = 8'd0;
    mreset();
    repeat (3) cyc();
    check("rst_pos", bus.pos, 128);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_level", bus.level, 0);
    rstn = 1'b1;
    cyc();
    // 128 -> 160 in four ticks spaced TICK_DIV cycles apart
    push(160);
    prev = bus.pos;
    for (int i = 0; i < 80 && bus.busy; i++) begin
      cyc();
      if (bus.pos != 8'(prev)) begin
        vals.push_back(bus.pos);
        times.push_back(i);
        prev = bus.pos;
      end
    end
    check("slew_changes", vals.size(), 4);
    for (int k = 0; k < vals.size(); k++) check("slew_value", vals[k], 136 + 8 * k);
    for (int k = 1; k < times.size(); k++) check("slew_spacing", times[k] - times[k-1], TICK_DIV);
    check("slew_busy_done", bus.busy, 0);
    // small move, top boundary, bottom boundary
    push(128); wait_idle(200);
    push(130); wait_idle(200);
    check("small_step", bus.pos, 130);
    push(250); wait_idle(400);
    push(255); wait_idle(200);
    check("top_clamp", bus.pos, 255);
    push(5); wait_idle(400);
    push(0); wait_idle(200);
    check("bottom_clamp", bus.pos, 0);
    // long slew with a held stream of targets filling the FIFO
    m_log.delete();
    saw_full = 1'b0;
    push(250);
    for (int t = 10; t <= 60; t += 10) push(t);
    wait_idle(3000);
    check("full_seen", saw_full, 1);
    check("full_final", bus.pos, 60);
    exp_log = '{250, 10, 20, 30, 40, 50, 60};
    check("order_count", m_log.size(), 7);
    for (int k = 0; k < 7 && k < m_log.size(); k++) check("order", m_log[k], exp_log[k]);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      bus.cmd_valid = ($urandom_range(0, 2) == 0);
      bus.cmd_pos = 8'($urandom_range(0, 255));
      cyc();
    end
    bus.cmd_valid = 1'b0;
    wait_idle(6000);
    // asynchronous reset mid-slew discards queued targets
    rstn = 1'b0; cyc(); rstn = 1'b1; cyc();
    push(200); push(10); push(20); push(30);
    for (int i = 0; i < 40 && bus.pos != 8'd144; i++) cyc();
    check("pre_rst_pos", bus.pos, 144);
    check("pre_rst_level", bus.level, 3);
    #2 rstn = 1'b0;
    #1;
    mreset();
    check("async_rst_pos", bus.pos, 128);
    check("async_rst_level", bus.level, 0);
    check("async_rst_busy", bus.busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    t_a = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (bus.pos != 8'd128) t_a++;
    end
    check("no_stale_exec", t_a, 0);
    // back-to-back targets: spacing between reaching 136 and stepping to 144
    t_a = -1;
    t_b = -1;
    bus.cmd_valid = 1'b1; bus.cmd_pos = 8'd136;
    cyc();
    bus.cmd_pos = 8'd144;
    cyc();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 100 && t_b < 0; i++) begin
      cyc();
      if (t_a < 0 && bus.pos == 8'd136) t_a = i;
      if (t_b < 0 && bus.pos == 8'd144) t_b = i;
    end
    check("hold_cycles", t_b - t_a, TICK_DIV * (DW_EN ? DWELL_TICKS + 1 : 1));
    wait_idle(100);
    check("hold_final", bus.pos, 144);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/servo_pos_sequencer.md
# servo_pos_sequencer

Command-driven position sequencer that sits directly upstream of the servo PWM unit and drives its 8-bit `pos` input. It accepts target positions through a valid/ready handshake and queues them in a small FIFO. It then slews `pos` toward each target at a fixed rate of STEP units per slew tick, so the servo never jumps. Targets are executed strictly in order, one at a time.

## Interface
- `TICK_DIV`, 4096: clock cycles per slew tick; must be ≥ 2.
- `STEP`, 4: position units moved per tick; range 1–255.
- `DEPTH`, 4: command FIFO entries; power of two, ≥ 2.
- `RESET_POS`, 128: value of `pos` after reset (servo centre).
- `DWELL_TICKS`, 8: ticks held at each reached target; used only with the dwell macro.

- `clk`  in  1  system clock; all logic on posedge.
- `rstn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  a target is offered.
- `cmd_pos`  in  8  target position, 0–255.
- `cmd_ready`  out  1  FIFO not full; a push occurs on `cmd_valid & cmd_ready` at a clock edge.
- `pos`  out  8  current position; connects to the PWM unit's `pos` input.
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Reset values (asynchronous): `pos` = RESET_POS, FIFO empty, `level` = 0, `cmd_ready` = 1, `busy` = 0, tick counter = 0, FSM = IDLE, target = RESET_POS.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1 that wraps to 0.
  - `tick` is high combinationally when count = TICK_DIV-1.
  - The counter runs in every state.
- FSM states are IDLE, SLEW and DWELL. DWELL exists only with the dwell macro.
- IDLE: when the FIFO is non-empty, pop the head into `target` on that edge and go to SLEW. An empty FIFO stays IDLE; there is no fall-through.
- SLEW: `pos` changes only on tick edges.
  - Compute a 9-bit unsigned difference d = |target − pos|.
  - If d ≤ STEP: `pos` <= target, then go to DWELL (or IDLE without the macro).
  - Else: `pos` <= pos ± STEP in the direction of the target.
  - `pos` never wraps, because the final step is clamped to the target.
  - target = pos on load: `pos` is unchanged and the FSM exits on the next tick.
- DWELL:
  - Count DWELL_TICKS ticks, then go to IDLE.
  - A dwell counter reaching DWELL_TICKS on a tick edge ends the dwell.
- FIFO:
  - A push when full is impossible, since `cmd_ready` = 0.
  - A push and a pop in the same cycle are both performed and `level` is unchanged.
  - A push into an empty FIFO is not popped until the following cycle.
- `cmd_pos` is sampled only on accepted pushes.

## Timing
- Push accepted at edge E0 → `level` = 1 after E0 → popped at E1 → FSM is SLEW after E1.
- The first `pos` change happens at the first tick edge after E1.
- `pos` changes at most once per TICK_DIV cycles.
- Time to reach a target: ceil(d / STEP) ticks.
- `cmd_ready` and `level` are registered-state derived, with no combinational path from `cmd_valid`.
- Reset asserted mid-slew: outputs return immediately to their reset values and queued commands are discarded. After release, the first pop occurs no earlier than the second edge.

## Configuration
- `SERVO_SEQ_DWELL_EN` defined: the DWELL state and dwell counter are compiled in. Each reached target is held for DWELL_TICKS ticks before the next pop.
- Not defined: no DWELL state and no dwell counter. The FSM goes SLEW→IDLE directly, and the next command may be popped on the edge after the target is reached. The `DWELL_TICKS` parameter is ignored.

## Structure
- Package `servo_pkg`:
  - `pos_t` (logic [7:0]).
  - FSM state enum `seq_state_e` (IDLE, SLEW, DWELL).
  - Constants `POS_MIN` = 0 and `POS_MAX` = 255.
- Sub-module `servo_cmd_fifo`: synchronous FIFO parameterised by DEPTH, with push/pop/full/empty/level ports and async active-low reset.
- Tick counter, FSM and slew arithmetic live in the top module.

## Test plan
Parameters for all scenarios: TICK_DIV=4, STEP=8, DEPTH=4.
- Reset release → `pos`=128, `cmd_ready`=1, `busy`=0, `level`=0.
- Push 160 → `pos` goes 136, 144, 152, 160 on four successive ticks (4 cycles apart); `busy` falls after 160 is reached.
- From 128, push 130 → `pos`=130 after one tick. Then push 255 from 250 → `pos`=255 with no wrap. Then push 0 from 5 → `pos`=0.
- Hold `cmd_valid` with targets 10, 20, 30, 40, 50, 60 during a long slew → `cmd_ready` low while `level`=4. No command is lost or duplicated, and targets are reached in order.
- Assert `rstn` low mid-slew at `pos`=144 with 3 entries queued → `pos`=128 and `level`=0 immediately. After release, no queued target is ever executed.
- With `SERVO_SEQ_DWELL_EN` and DWELL_TICKS=2, push 136 then 144 → `pos` holds at 136 for 2 ticks before stepping to 144. Without the macro, the next step follows one tick after 136 is reached.
